m3_six_step_pwm_driver: RTL and testbench

Downstream consumer of the m3 power/speed calculation path. It converts the commutation step period and power level into six-step trapezoidal commutation with high-side PWM for the three motor phases. It inserts dead time at every commutation edge and pulses `roundDoneO` once per electrical revolution, which feeds the speed calculator's next-round input.

---
 rtl/m3_six_step_pwm_driver.sv | 171 +++++++++++++++++
 tb/tb_m3_six_step_pwm_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_six_step_pwm_driver.sv
// Six-step trapezoidal commutation with high-side PWM and dead time.
// Pulses roundDoneO once per electrical revolution in one direction.
module m3_six_step_pwm_driver #(
  parameter int PERIOD_W   = 16,
  parameter int POWER_W    = 8,
  parameter int PWM_MAX    = 100,
  parameter int MIN_PERIOD = 200,
  parameter int DEAD       = 4
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                workingI,
  input  logic                m3forceStopI,
  input  logic                m3invRotateI,
  input  logic [PERIOD_W-1:0] stepPeriodI,
  input  logic [POWER_W-1:0]  powerI,
  output logic                uHo,
  output logic                uLo,
  output logic                vHo,
  output logic                vLo,
  output logic                wHo,
  output logic                wLo,
  output logic [2:0]          stepIdxO,
  output logic                stepTickO,
  output logic                roundDoneO
);

  localparam int CW = $clog2(PWM_MAX + 1);
  localparam logic [CW-1:0] PwmMax = CW'(PWM_MAX);
  localparam logic [CW-1:0] PwmLast = CW'(PWM_MAX - 1);
  localparam logic [PERIOD_W-1:0] MinPer = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DeadLast = PERIOD_W'(DEAD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEADT,
    RUN
  } state_t;

  state_t              state;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] period;
  logic [2:0]          stepIdx;
  logic [2:0]          roundCnt;
  logic [CW-1:0]       pwmCnt;
  logic [CW-1:0]       duty;
  logic                dir;
  logic [5:0]          gates;

  logic                stop;
  logic                boundary;
  logic                pwmWrap;
  logic                hiOn;
  logic                loOn;
  logic [PERIOD_W-1:0] periodNext;
  logic [CW-1:0]       dutyNext;
  logic [2:0]          stepNext;
  logic [5:0]          gNext;

  assign stop     = m3forceStopI | ~workingI;
  assign boundary = (state != IDLE) &&
                    (timer == period - PERIOD_W'(1));
  assign pwmWrap  = (pwmCnt == PwmLast);
  assign hiOn     = (state == RUN) && (pwmCnt < duty);
  assign loOn     = (state == RUN);

  assign periodNext = (stepPeriodI < MinPer) ? MinPer
                                             : stepPeriodI;

  always_comb begin
    dutyNext = PwmMax;
    if (32'(powerI) < 32'(PWM_MAX)) dutyNext = CW'(powerI);
  end

  always_comb begin
    stepNext = 3'd0;
    unique case (1'b1)
      m3invRotateI && (stepIdx == 3'd0): stepNext = 3'd5;
      m3invRotateI && (stepIdx != 3'd0): stepNext = stepIdx - 3'd1;
      !m3invRotateI && (stepIdx >= 3'd5): stepNext = 3'd0;
      !m3invRotateI && (stepIdx < 3'd5): stepNext = stepIdx + 3'd1;
    endcase
  end

  // gate order {uH, uL, vH, vL, wH, wL}; H and L of a phase never share a row
  always_comb begin
    gNext = 6'b000000;
    case (stepIdx)
      3'd0: gNext = {hiOn, 1'b0, 1'b0, loOn, 1'b0, 1'b0};
      3'd1: gNext = {hiOn, 1'b0, 1'b0, 1'b0, 1'b0, loOn};
      3'd2: gNext = {1'b0, 1'b0, hiOn, 1'b0, 1'b0, loOn};
      3'd3: gNext = {1'b0, loOn, hiOn, 1'b0, 1'b0, 1'b0};
      3'd4: gNext = {1'b0, loOn, 1'b0, 1'b0, hiOn, 1'b0};
      3'd5: gNext = {1'b0, 1'b0, 1'b0, loOn, hiOn, 1'b0};
      default: gNext = 6'b000000;
    endcase
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state      <= IDLE;
      timer      <= '0;
      period     <= MinPer;
      stepIdx    <= 3'd0;
      roundCnt   <= 3'd0;
      pwmCnt     <= '0;
      duty       <= '0;
      dir        <= 1'b0;
      gates      <= 6'b000000;
      stepTickO  <= 1'b0;
      roundDoneO <= 1'b0;
    end else if (stop) begin
      state      <= IDLE;
      timer      <= '0;
      stepIdx    <= 3'd0;
      roundCnt   <= 3'd0;
      pwmCnt     <= '0;
      gates      <= 6'b000000;
      stepTickO  <= 1'b0;
      roundDoneO <= 1'b0;
    end else begin
      gates      <= gNext;
      stepTickO  <= 1'b0;
      roundDoneO <= 1'b0;
      unique case (state)
        IDLE: begin
          state    <= DEADT;
          timer    <= '0;
          period   <= periodNext;
          dir      <= m3invRotateI;
          pwmCnt   <= '0;
          duty     <= dutyNext;
          roundCnt <= 3'd0;
        end
        DEADT, RUN: begin
          if (pwmWrap) begin
            pwmCnt <= '0;
            duty   <= dutyNext;
          end else begin
            pwmCnt <= pwmCnt + CW'(1);
          end
          if (boundary) begin
            timer     <= '0;
            state     <= DEADT;
            period    <= periodNext;
            dir       <= m3invRotateI;
            stepIdx   <= stepNext;
            stepTickO <= 1'b1;
            // a reversal starts a fresh revolution count
            if (m3invRotateI != dir) begin
              roundCnt <= 3'd0;
            end else if (roundCnt == 3'd5) begin
              roundCnt   <= 3'd0;
              roundDoneO <= 1'b1;
            end else begin
              roundCnt <= roundCnt + 3'd1;
            end
          end else begin
            timer <= timer + PERIOD_W'(1);
            if (state == DEADT && timer == DeadLast) state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {uHo, uLo, vHo, vLo, wHo, wLo} = gates;
  assign stepIdxO = stepIdx;

endmodule

// File: tb/tb_m3_six_step_pwm_driver.sv
// Directed self-checking bench for m3_six_step_pwm_driver.
// Expected values are hand-derived from DEAD=4, PWM_MAX=100, MIN_PERIOD=200.
module tb_m3_six_step_pwm_driver;

  logic        clkI = 1'b0;
  logic        nRstI;
  logic        workingI;
  logic        m3forceStopI;
  logic        m3invRotateI;
  logic [15:0] stepPeriodI;
  logic [7:0]  powerI;
  logic        uHo, uLo, vHo, vLo, wHo, wLo;
  logic [2:0]  stepIdxO;
  logic        stepTickO;
  logic        roundDoneO;

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;

  m3_six_step_pwm_driver dut (
    .clkI        (clkI),
    .nRstI       (nRstI),
    .workingI    (workingI),
    .m3forceStopI(m3forceStopI),
    .m3invRotateI(m3invRotateI),
    .stepPeriodI (stepPeriodI),
    .powerI      (powerI),
    .uHo         (uHo),
    .uLo         (uLo),
    .vHo         (vHo),
    .vLo         (vLo),
    .wHo         (wHo),
    .wLo         (wLo),
    .stepIdxO    (stepIdxO),
    .stepTickO   (stepTickO),
    .roundDoneO  (roundDoneO)
  );

  always #5 clkI = ~clkI;
  always @(posedge clkI) cyc <= cyc + 1;

  wire [5:0] g    = {uHo, uLo, vHo, vLo, wHo, wLo};
  wire       anyH = uHo | vHo | wHo;
  wire       anyL = uLo | vLo | wLo;

  always @(negedge clkI) begin
    nAssert++;
    assert (!((uHo && uLo) || (vHo && vLo) || (wHo && wLo)))
    else begin
      nFail++;
      $error("FAIL shootThrough observed=%b expected=no phase with H&L", g);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge clkI);
    #1;
  endtask

  task automatic waitTick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clkI);
      #1;
      if (stepTickO === 1'b1) begin
        at = cyc;
        break;
      end
    end
    nAssert++;
    assert (at >= 0)
    else begin
      nFail++;
      $error("FAIL tickTimeout observed=none expected=tick in %0d", budget);
    end
  endtask

  task automatic window(input int n, output int nh, output int nl);
    nh = 0;
    nl = 0;
    for (int i = 0; i < n; i++) begin
      clk(1);
      nh += int'(anyH);
      nl += int'(anyL);
    end
  endtask

  initial begin
    int c0, at, last, nh, nl;
    int expF[6];
    int expR[7];
    expF = '{1, 2, 3, 4, 5, 0};
    expR = '{2, 1, 0, 5, 4, 3, 2};

    nRstI        = 1'b0;
    workingI     = 1'b0;
    m3forceStopI = 1'b0;
    m3invRotateI = 1'b0;
    stepPeriodI  = 16'd1000;
    powerI       = 8'd50;
    clk(3);
    chk("rstGates", g, 0);
    chk("rstStep", stepIdxO, 0);
    chk("rstTick", stepTickO, 0);
    chk("rstRound", roundDoneO, 0);

    nRstI = 1'b1;
    clk(2);
    chk("idleGates", g, 0);

    // start forward: first conduction DEAD+1 edges after workingI seen
    workingI = 1'b1;
    c0 = cyc;
    clk(5);
    chk("deadBeforeStart", g, 0);
    clk(1);
    chk("startGates", g, 6'b100100);

    nh = 0;
    nl = 0;
    for (int i = 0; i < 100; i++) begin
      clk(1);
      nh += int'(uHo);
      nl += int'(vLo);
    end
    chk("duty50High", nh, 50);
    chk("duty50Low", nl, 100);

    last = c0;
    for (int i = 0; i < 6; i++) begin
      waitTick(2000, at);
      chk("fwdSpacing", at - last, (i == 0) ? 1001 : 1000);
      chk("fwdStep", stepIdxO, expF[i]);
      chk("fwdRound", roundDoneO, (i == 5) ? 1 : 0);
      last = at;
      if (i == 0) begin
        for (int d = 0; d < 4; d++) begin
          clk(1);
          chk("deadTime", g, 0);
        end
        clk(1);
        chk("step1Gates", g, 6'b100001);
      end
    end

    // period change mid-step, then the floor
    stepPeriodI = 16'd500;
    waitTick(2000, at);
    chk("perOld", at - last, 1000);
    chk("perOldStep", stepIdxO, 1);
    last = at;
    stepPeriodI = 16'd10;
    waitTick(2000, at);
    chk("perNew", at - last, 500);
    last = at;
    waitTick(2000, at);
    chk("perFloor", at - last, 200);
    chk("perFloorStep", stepIdxO, 3);
    last = at;

    // reversal mid-round restarts the revolution count
    m3invRotateI = 1'b1;
    for (int i = 0; i < 7; i++) begin
      waitTick(1000, at);
      chk("revSpacing", at - last, 200);
      chk("revStep", stepIdxO, expR[i]);
      chk("revRound", roundDoneO, (i == 6) ? 1 : 0);
      last = at;
    end

    // duty limits, measured over one full 200-cycle step
    powerI = 8'd0;
    waitTick(1000, at);
    waitTick(1000, at);
    window(200, nh, nl);
    chk("duty0High", nh, 0);
    chk("duty0Low", nl, 196);

    // new power waits for the carrier wrap
    for (int i = 0; i < 200; i++) begin
      if (((cyc - c0 - 1) % 100) == 10) break;
      clk(1);
    end
    chk("phaseAlign", (cyc - c0 - 1) % 100, 10);
    powerI = 8'd100;
    nh = 0;
    for (int i = 0; i < 90; i++) begin
      clk(1);
      nh += int'(anyH);
    end
    chk("noEarlyDuty", nh, 0);

    waitTick(1000, at);
    window(200, nh, nl);
    chk("duty100High", nh, 196);
    chk("duty100Low", nl, 196);

    powerI = 8'd255;
    waitTick(1000, at);
    waitTick(1000, at);
    window(200, nh, nl);
    chk("duty255High", nh, 196);

    // force stop during conduction
    waitTick(1000, at);
    clk(50);
    chk("preStopLow", anyL, 1);
    m3forceStopI = 1'b1;
    clk(1);
    chk("stopGates", g, 0);
    chk("stopStep", stepIdxO, 0);
    workingI = 1'b0;
    clk(2);
    workingI = 1'b1;
    clk(20);
    chk("stopHoldGates", g, 0);
    chk("stopHoldStep", stepIdxO, 0);

    m3forceStopI = 1'b0;
    clk(5);
    chk("restartDead", g, 0);
    clk(1);
    chk("restartGates", g, 6'b100100);

    // workingI low
    clk(20);
    chk("preIdleLow", anyL, 1);
    workingI = 1'b0;
    clk(1);
    chk("workOffGates", g, 0);
    chk("workOffStep", stepIdxO, 0);

    // asynchronous reset mid-conduction
    workingI = 1'b1;
    clk(30);
    chk("preRstLow", anyL, 1);
    #2;
    nRstI = 1'b0;
    #1;
    chk("asyncRstGates", g, 0);
    chk("asyncRstStep", stepIdxO, 0);
    clk(1);
    nRstI = 1'b1;
    clk(5);
    chk("postRstDead", g, 0);
    clk(1);
    chk("postRstGates", g, 6'b100100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
